// File: rtl/btb_2bit.sv
// Fully associative branch target buffer with 2-bit saturating direction counters,
// round-robin allocation, EXE-stage mispredict detection and a saturating mispredict counter.
module btb_2bit #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cur_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_pc,
  input  logic              inval,
  output logic              mispredict,
  output logic [ADDR_W-1:0] correct_pc,
  output logic [CNT_W-1:0]  mp_count
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tag_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   mp_q, mp_d;

  logic [ENTRIES-1:0] lk_match, up_match;
  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic               lk_hit, up_hit;

  // Two independent CAM searches: fetch-side lookup and EXE-side update match.
  always_comb begin
    lk_match = '0;
    up_match = '0;
    lk_idx   = '0;
    up_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match[i] = valid_q[i] && (tag_q[i] == cur_pc);
      up_match[i] = valid_q[i] && (tag_q[i] == upd_pc);
      if (lk_match[i]) lk_idx = IDX_W'(i);
      if (up_match[i]) up_idx = IDX_W'(i);
    end
  end

  assign lk_hit = $onehot(lk_match);
  assign up_hit = $onehot(up_match);

  always_comb begin
    pred_taken = lk_hit && ctr_q[lk_idx][1];
    pred_pc    = pred_taken ? tgt_q[lk_idx] : cur_pc + PC_ONE;
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_pc)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + PC_ONE;
  assign mp_count   = mp_q;

  // Invalidate wins over a same-cycle update, which is dropped entirely.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    if (inval) begin
      valid_d = '0;
      rr_d    = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
          tgt_d[up_idx] = upd_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_d[rr_q] = 1'b1;
        tag_d[rr_q]   = upd_pc;
        tgt_d[rr_q]   = upd_target;
        ctr_d[rr_q]   = 2'b10;
        rr_d          = rr_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    mp_d = mp_q;
    if (mispredict && (mp_q != '1)) mp_d = mp_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rr_q    <= '0;
      mp_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      mp_q    <= mp_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= tag_d[i];
        tgt_q[i] <= tgt_d[i];
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

endmodule

// File: doc/btb_2bit.md
BTB_2BIT -- requirements
Module: btb_2bit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning PC/target width in instruction words.
REQ-002 SHALL have parameter ENTRIES, default 8, meaning number of table entries; power of two, >=2.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the mispredict statistics counter.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset; asynchronous, active-high.
REQ-006 SHALL have port cur_pc  input  ADDR_W  meaning PC of the instruction being fetched.
REQ-007 SHALL have port pred_taken  output  1  meaning fetch-side taken prediction for cur_pc.
REQ-008 SHALL have port pred_pc  output  ADDR_W  meaning predicted next fetch PC.
REQ-009 SHALL have port upd_valid  input  1  meaning a branch or jump is resolved this cycle in EXE.
REQ-010 SHALL have port upd_pc  input  ADDR_W  meaning PC of the resolved branch.
REQ-011 SHALL have port upd_taken  input  1  meaning actual branch outcome.
REQ-012 SHALL have port upd_target  input  ADDR_W  meaning actual taken target.
REQ-013 SHALL have port upd_pred_taken  input  1  meaning prediction made at fetch and carried down the pipe.
REQ-014 SHALL have port upd_pred_pc  input  ADDR_W  meaning predicted next PC carried down the pipe.
REQ-015 SHALL have port inval  input  1  meaning invalidate all entries.
REQ-016 SHALL have port mispredict  output  1  meaning flush request for IF/ID.
REQ-017 SHALL have port correct_pc  output  ADDR_W  meaning PC to refetch on mispredict.
REQ-018 SHALL have port mp_count  output  CNT_W  meaning number of mispredicts since reset.

Function
REQ-019 SHALL keep per entry: valid, tag (ADDR_W bits, full PC), target (ADDR_W), 2-bit saturating counter; fully associative lookup.
REQ-020 SHALL declare a hit when exactly one valid entry's tag equals cur_pc; lookup combinational, zero-cycle latency.
REQ-021 SHALL drive pred_taken = hit AND counter[1]; pred_pc = entry target if pred_taken, else cur_pc+1, with wrap modulo 2^ADDR_W.
REQ-022 SHALL drive mispredict combinationally = upd_valid AND (upd_taken != upd_pred_taken OR (upd_taken AND upd_target != upd_pred_pc)).
REQ-023 SHALL drive correct_pc = upd_target if upd_taken, else upd_pc+1 (wrapping); value is don't-care when mispredict=0.
REQ-024 SHALL, on upd_valid with upd_pc hitting an entry, saturating-increment the counter if taken (max 11), else saturating-decrement it (min 00), and load target<=upd_target if taken.
REQ-025 SHALL, on upd_valid with an upd_pc miss and upd_taken=1, allocate the entry at round-robin pointer rr_ptr: valid=1, tag=upd_pc, target=upd_target, counter=10, then rr_ptr <= (rr_ptr+1) mod ENTRIES.
REQ-026 SHALL leave the table and rr_ptr unchanged on a miss with upd_taken=0.
REQ-027 SHALL overwrite a valid entry at rr_ptr on allocation without regard to its counter.
REQ-028 SHALL apply updates at the next rising edge; a same-cycle lookup of upd_pc sees pre-update state, with no bypass.
REQ-029 SHALL increment mp_count on every edge where mispredict=1, saturating at all-ones.
REQ-030 SHALL, on inval=1, clear all valid bits and rr_ptr at the next edge; inval takes priority over a simultaneous update, which is discarded; mp_count is unaffected by inval.
REQ-031 SHALL never produce duplicate tags, since updates match existing entries before allocating.

Reset
REQ-032 SHALL, while rst=1, asynchronously clear all valid bits, set all counters to 01, targets/tags to 0, rr_ptr to 0, and mp_count to 0.
REQ-033 SHALL, during and after reset until the first allocation, output pred_taken=0 and pred_pc=cur_pc+1; mispredict and correct_pc follow REQ-022/REQ-023 as pure functions of their inputs.
REQ-034 SHALL, when rst asserts mid-update, discard the update; the table ends in the reset state.

Verification
REQ-035 SHALL verify allocation: after reset, apply upd_valid=1 with upd_pc=0x0010, upd_taken=1, upd_target=0x0040 and upd_pred_taken=0 -> mispredict=1, correct_pc=0x0040, mp_count=1 next cycle; then cur_pc=0x0010 -> pred_taken=1, pred_pc=0x0040.
REQ-036 SHALL verify hysteresis: starting from the entry in REQ-035, send two not-taken updates -> counter 10->01->00, and cur_pc=0x0010 gives pred_taken=0, pred_pc=0x0011; then one taken update -> counter 01, still not predicted taken.
REQ-037 SHALL verify round-robin replacement: with ENTRIES=8, allocate 9 distinct taken branches 0x0100..0x0108 -> 0x0100 misses (pred_pc=0x0101), while 0x0101..0x0108 all hit.
REQ-038 SHALL verify invalidate priority: inval=1 in the same cycle as a taken update for a new PC -> all lookups miss afterward and rr_ptr=0.
REQ-039 SHALL verify wrap and saturation: cur_pc=0xFFFF on a miss -> pred_pc=0x0000; with CNT_W=2, 5 mispredicts -> mp_count=3.
REQ-040 SHALL verify async reset: assert rst between clock edges after allocations -> pred_taken=0 and mp_count=0 immediately, without a clock edge.
